// File: rtl/i2c_master_pkg.sv
// rtl/i2c_master_pkg.sv - shared constants, state encoding and helpers for i2c_master
package i2c_master_pkg;

  localparam int MAX_BYTES     = 9;
  localparam int TICKS_PER_BIT = 4;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE      = 4'd0;
  localparam state_t S_START     = 4'd1;
  localparam state_t S_ADDR      = 4'd2;
  localparam state_t S_ADDR_ACK  = 4'd3;
  localparam state_t S_WRITE     = 4'd4;
  localparam state_t S_WRITE_ACK = 4'd5;
  localparam state_t S_READ      = 4'd6;
  localparam state_t S_READ_ACK  = 4'd7;
  localparam state_t S_STOP      = 4'd8;

  localparam logic [1:0] PH_LAST = 2'(TICKS_PER_BIT - 1);

  function automatic logic [3:0] clamp_size(input logic [7:0] n);
    return (n > 8'(MAX_BYTES)) ? 4'(MAX_BYTES) : n[3:0];
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// rtl/i2c_tick_gen.sv - prescaler counter producing one tick every period+1 clocks
module i2c_tick_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] period,
  output logic        tick
);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      count <= '0;
    end else if (count == period) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign tick = run && (count == period);

endmodule

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-master I2C controller: address, up to 9 write bytes or read bytes
module i2c_master
  import i2c_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i2c,
  input  logic [7:0]  addr,
  input  logic [15:0] prescaler,
  input  logic [71:0] data_to_send,
  input  logic [7:0]  data_size,
  output logic [7:0]  data_received,
  output logic        error,
  inout  tri logic    sda,
  output tri logic    scl,
  output logic        valid_trans,
  output logic        valid_recep
);

  state_t      state;
  logic [1:0]  phase;
  logic [2:0]  bit_cnt;
  logic [3:0]  byte_cnt;
  logic [3:0]  size_q;
  logic        rw_q;
  logic [7:0]  tx_byte;
  logic [71:0] data_q;
  logic [7:0]  rx_byte;
  logic        ack_q;
  logic        sda_low;
  logic        bus_free;
  logic [15:0] presc_q;
  logic        tick;
  logic        run;
  logic        p_drive;
  logic        p_sample;
  logic        p_end;
  logic        last_byte;

  assign run       = (state != S_IDLE) || !bus_free;
  assign p_drive   = tick && (phase == 2'd0);
  assign p_sample  = tick && (phase == 2'd2);
  assign p_end     = tick && (phase == PH_LAST);
  assign last_byte = (byte_cnt + 4'd1) == size_q;

  i2c_tick_gen u_tick (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .period (presc_q),
    .tick   (tick)
  );

  // SCL is held low for the first half of every bit, and released in IDLE/START
  assign scl = ((state != S_IDLE) && (state != S_START) && !phase[1]) ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      phase         <= 2'd0;
      bit_cnt       <= 3'd0;
      byte_cnt      <= 4'd0;
      size_q        <= 4'd0;
      rw_q          <= 1'b0;
      tx_byte       <= 8'h00;
      data_q        <= '0;
      rx_byte       <= 8'h00;
      ack_q         <= 1'b1;
      sda_low       <= 1'b0;
      bus_free      <= 1'b1;
      presc_q       <= 16'd0;
      error         <= 1'b0;
      data_received <= 8'h00;
      valid_trans   <= 1'b0;
      valid_recep   <= 1'b0;
    end else begin
      valid_trans <= 1'b0;
      valid_recep <= 1'b0;
      if (tick) phase <= phase + 2'd1;

      case (state)
        S_IDLE: begin
          if (!bus_free) begin
            if (p_end) bus_free <= 1'b1;
          end else if (start_i2c) begin
            state    <= S_START;
            phase    <= 2'd0;
            tx_byte  <= addr;
            rw_q     <= addr[0];
            data_q   <= data_to_send;
            size_q   <= clamp_size(data_size);
            presc_q  <= prescaler;
            error    <= 1'b0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 4'd0;
          end
        end

        S_START: begin
          if (tick && (phase == 2'd1)) sda_low <= 1'b1;
          if (p_end) state <= S_ADDR;
        end

        S_ADDR, S_WRITE: begin
          if (p_drive) sda_low <= ~tx_byte[7];
          if (p_end) begin
            tx_byte <= {tx_byte[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= (state == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
          end
        end

        S_ADDR_ACK: begin
          if (p_drive) sda_low <= 1'b0;
          if (p_sample) ack_q <= sda;
          if (p_end) begin
            if (ack_q) begin
              error <= 1'b1;
              state <= S_STOP;
            end else if (size_q == 4'd0) begin
              state <= S_STOP;
            end else if (rw_q) begin
              state <= S_READ;
            end else begin
              state   <= S_WRITE;
              tx_byte <= data_q[71:64];
              data_q  <= {data_q[63:0], 8'h00};
            end
          end
        end

        S_WRITE_ACK: begin
          if (p_drive) sda_low <= 1'b0;
          if (p_sample) ack_q <= sda;
          if (p_end) begin
            if (ack_q) begin
              error <= 1'b1;
              state <= S_STOP;
            end else begin
              valid_trans <= 1'b1;
              byte_cnt    <= byte_cnt + 4'd1;
              if (last_byte) begin
                state <= S_STOP;
              end else begin
                state   <= S_WRITE;
                tx_byte <= data_q[71:64];
                data_q  <= {data_q[63:0], 8'h00};
              end
            end
          end
        end

        S_READ: begin
          if (p_drive) sda_low <= 1'b0;
          if (p_sample) rx_byte <= {rx_byte[6:0], sda};
          if (p_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              data_received <= rx_byte;
              valid_recep   <= 1'b1;
              state         <= S_READ_ACK;
            end
          end
        end

        S_READ_ACK: begin
          // the final byte is NACKed so the slave lets go of SDA before STOP
          if (p_drive) sda_low <= !last_byte;
          if (p_end) begin
            byte_cnt <= byte_cnt + 4'd1;
            state    <= last_byte ? S_STOP : S_READ;
          end
        end

        S_STOP: begin
          if (p_drive) sda_low <= 1'b1;
          if (p_end) begin
            sda_low  <= 1'b0;
            bus_free <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - vector table plus slave model and scoreboard for i2c_master
module tb_i2c_master;

  typedef struct {
    logic [7:0]  addr;
    logic [71:0] data;
    logic [7:0]  size;
    int          nack_at;
    logic [71:0] rd;
    int          exp_err;
    int          exp_vt;
    int          exp_vr;
    int          exp_last;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i2c;
  logic [7:0]  addr;
  logic [15:0] prescaler;
  logic [71:0] data_to_send;
  logic [7:0]  data_size;
  logic [7:0]  data_received;
  logic        error;
  logic        valid_trans;
  logic        valid_recep;
  tri          sda;
  tri          scl;
  logic        slv_low;
  logic        sda_v;
  logic        scl_v;

  pullup (sda);
  pullup (scl);
  assign sda   = slv_low ? 1'b0 : 1'bz;
  assign sda_v = (sda === 1'b0) ? 1'b0 : 1'b1;
  assign scl_v = (scl === 1'b0) ? 1'b0 : 1'b1;

  i2c_master dut (
    .clk           (clk),
    .rst           (rst),
    .start_i2c     (start_i2c),
    .addr          (addr),
    .prescaler     (prescaler),
    .data_to_send  (data_to_send),
    .data_size     (data_size),
    .data_received (data_received),
    .error         (error),
    .sda           (sda),
    .scl           (scl),
    .valid_trans   (valid_trans),
    .valid_recep   (valid_recep)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0, n_stop = 0, n_vt = 0, n_vr = 0;
  int cur_size = 0, cur_nack = -1;
  logic [7:0] rd_bytes [0:8];
  logic [7:0] exp_bytes [$];
  logic [7:0] exp_rx [$];
  vec_t vecs [7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slave model: decodes START/STOP, captures bytes, ACKs, serves read data
  int         bc = 0, rd_idx = 0, wr_cnt = 0;
  logic       in_addr = 1'b0, active = 1'b0, rw = 1'b0, rd_active = 1'b0;
  logic [7:0] rx = 8'h00;
  logic       prev_sda = 1'b1, prev_scl = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0; slv_low = 1'b0; bc = 0; in_addr = 1'b0; rd_active = 1'b0;
      prev_sda = 1'b1; prev_scl = 1'b1;
    end else begin
      if (scl_v && prev_scl && prev_sda && !sda_v) begin
        n_start++; active = 1'b1; in_addr = 1'b1; bc = 0; wr_cnt = 0; rd_idx = 0;
        rd_active = 1'b0; slv_low = 1'b0;
      end else if (scl_v && prev_scl && !prev_sda && sda_v) begin
        n_stop++; active = 1'b0; slv_low = 1'b0;
      end else if (active && scl_v && !prev_scl) begin
        if (bc < 8) begin
          rx = {rx[6:0], sda_v};
          if (bc == 7) begin
            if (in_addr) rw = rx[0];
            if (in_addr || !rw) begin
              chk("bus_byte_expected", int'(exp_bytes.size() > 0), 1);
              if (exp_bytes.size() > 0) chk("bus_byte", int'(rx), int'(exp_bytes.pop_front()));
              if (!in_addr) wr_cnt++;
            end
          end
          bc++;
        end else begin
          if (in_addr) begin
            in_addr   = 1'b0;
            rd_active = rw && (cur_nack != 0);
          end else if (rd_active) begin
            chk("master_ack_bit", int'(sda_v), int'(rd_idx == cur_size - 1));
            if (!sda_v) rd_idx++;
            else rd_active = 1'b0;
          end
          bc = 0;
        end
      end else if (active && !scl_v && prev_scl) begin
        slv_low = 1'b0;
        if (bc == 8) begin
          if (in_addr) slv_low = (cur_nack != 0);
          else if (!rw) slv_low = (cur_nack != wr_cnt);
        end else if (rd_active) begin
          slv_low = !rd_bytes[rd_idx][3'(7 - bc)];
        end
      end
      prev_sda = sda_v;
      prev_scl = scl_v;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_trans) n_vt++;
      if (valid_recep) begin
        n_vr++;
        chk("recep_expected", int'(exp_rx.size() > 0), 1);
        if (exp_rx.size() > 0) chk("data_received", int'(data_received), int'(exp_rx.pop_front()));
      end
    end
  end

  task automatic launch(input vec_t v);
    int sz, nb;
    sz = (v.size > 8'd9) ? 9 : int'(v.size);
    cur_size = sz;
    cur_nack = v.nack_at;
    for (int k = 0; k < 9; k++) rd_bytes[k] = v.rd[71 - 8*k -: 8];
    exp_bytes.push_back(v.addr);
    if (!v.addr[0]) begin
      nb = (v.nack_at < 0) ? sz : ((v.nack_at < sz) ? v.nack_at : sz);
      for (int k = 0; k < nb; k++) exp_bytes.push_back(v.data[71 - 8*k -: 8]);
    end else if (v.nack_at != 0) begin
      for (int k = 0; k < sz; k++) exp_rx.push_back(rd_bytes[k]);
    end
    addr = v.addr; data_to_send = v.data; data_size = v.size; start_i2c = 1'b1;
  endtask

  task automatic wait_start(input int target);
    for (int i = 0; i < 400 && n_start < target; i++) @(negedge clk);
  endtask

  task automatic wait_stop(input int target);
    for (int i = 0; i < 4000 && n_stop < target; i++) @(negedge clk);
  endtask

  task automatic wait_scl(input logic lvl, input int budget, output int n);
    n = 0;
    while (scl_v !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int s0, p0, vt0, vr0;
    s0 = n_start; p0 = n_stop; vt0 = n_vt; vr0 = n_vr;
    @(negedge clk);
    launch(v);
    wait_start(s0 + 1);
    start_i2c = 1'b0;
    chk({tag, "_err_cleared"}, int'(error), 0);
    wait_stop(p0 + 1);
    repeat (2) @(negedge clk);
    chk({tag, "_starts"}, n_start - s0, 1);
    chk({tag, "_stops"}, n_stop - p0, 1);
    chk({tag, "_valid_trans"}, n_vt - vt0, v.exp_vt);
    chk({tag, "_valid_recep"}, n_vr - vr0, v.exp_vr);
    chk({tag, "_error"}, int'(error), v.exp_err);
    chk({tag, "_bytes_left"}, exp_bytes.size(), 0);
    if (v.exp_vr > 0) chk({tag, "_last_rx"}, int'(data_received), v.exp_last);
    exp_bytes.delete();
    exp_rx.delete();
  endtask

  initial begin
    int s0, p0, lo, hi, d, t_stop, t_start;
    vec_t v40;
    rst = 1'b1; start_i2c = 1'b0; addr = 8'h00; prescaler = 16'd3;
    data_to_send = '0; data_size = 8'd0;

    vecs[0] = '{8'hAA, 72'hDCAABBCCDD11223344, 8'd3,  -1, 72'h0, 0, 3, 0, 0};
    vecs[1] = '{8'hAB, 72'h0, 8'd3, -1, 72'h112233000000000000, 0, 0, 3, 'h33};
    vecs[2] = '{8'h20, 72'h123400000000000000, 8'd2, 0, 72'h0, 1, 0, 0, 0};
    vecs[3] = '{8'h40, 72'h0, 8'd0, -1, 72'h0, 0, 0, 0, 0};
    vecs[4] = '{8'h50, 72'h010203040506070809, 8'd12, -1, 72'h0, 0, 9, 0, 0};
    vecs[5] = '{8'h31, 72'h0, 8'd1, -1, 72'hA50000000000000000, 0, 0, 1, 'hA5};
    vecs[6] = '{8'h60, 72'h5AA53CC30000000000, 8'd4, 2, 72'h0, 1, 1, 0, 0};
    v40 = vecs[3];

    repeat (4) @(negedge clk);
    chk("rst_scl_released", int'(scl_v), 1);
    chk("rst_sda_released", int'(sda_v), 1);
    chk("rst_error", int'(error), 0);
    chk("rst_data_received", int'(data_received), 0);
    chk("rst_valid_trans", int'(valid_trans), 0);
    chk("rst_valid_recep", int'(valid_recep), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // SCL shape at prescaler 3
    s0 = n_start; p0 = n_stop;
    @(negedge clk);
    launch(v40);
    wait_start(s0 + 1);
    start_i2c = 1'b0;
    wait_scl(1'b0, 200, d);
    wait_scl(1'b1, 200, lo);
    wait_scl(1'b0, 200, hi);
    chk("scl_low_p3", lo, 8);
    chk("scl_high_p3", hi, 8);
    wait_stop(p0 + 1);
    chk("shape_stops", n_stop - p0, 1);
    exp_bytes.delete();

    // start_i2c held high across two transfers
    s0 = n_start; p0 = n_stop;
    @(negedge clk);
    launch(v40);
    exp_bytes.push_back(8'h40);
    wait_stop(p0 + 1);
    t_stop = cyc;
    wait_start(s0 + 2);
    t_start = cyc;
    start_i2c = 1'b0;
    wait_stop(p0 + 2);
    chk("bus_free_ge_4_ticks", int'((t_start - t_stop) >= 16), 1);
    chk("b2b_starts", n_start - s0, 2);
    chk("b2b_stops", n_stop - p0, 2);
    chk("b2b_bytes_left", exp_bytes.size(), 0);
    exp_bytes.delete();

    // reset during the second data bit
    s0 = n_start;
    @(negedge clk);
    launch(vecs[0]);
    wait_start(s0 + 1);
    start_i2c = 1'b0;
    for (int i = 0; i < 1000 && !(active && !in_addr && bc == 1 && !scl_v); i++) @(negedge clk);
    chk("rst_point_reached", int'(active && !in_addr && bc == 1 && !scl_v), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_scl", int'(scl_v), 1);
    chk("midrst_sda", int'(sda_v), 1);
    chk("midrst_error", int'(error), 0);
    chk("midrst_data_received", int'(data_received), 0);
    chk("midrst_valid_trans", int'(valid_trans), 0);
    chk("midrst_valid_recep", int'(valid_recep), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_bytes.delete();
    exp_rx.delete();
    run_vec(vecs[0], "post_rst");

    // prescaler 624, changed mid-transfer
    prescaler = 16'd624;
    s0 = n_start;
    @(negedge clk);
    launch(vecs[0]);
    wait_start(s0 + 1);
    start_i2c = 1'b0;
    prescaler = 16'd3;
    wait_scl(1'b0, 6000, d);
    wait_scl(1'b1, 3000, lo);
    wait_scl(1'b0, 3000, hi);
    chk("scl_low_p624", lo, 1250);
    chk("scl_high_p624", hi, 1250);
    chk("scl_period_p624", lo + hi, 2500);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_bytes.delete();
    exp_rx.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
